// File: rtl/rfsoc_config.sv
`default_nettype none
// ============================================================================
//  Package     : rfsoc_config
//  Description : Shared types and defaults for the RFSoC DAC playback path.
//                Holds the playback state encoding, default datapath/counter
//                widths and a helper that picks the first non-empty phase of
//                a shot.
//  Revision    : 1.0 - initial release
// ============================================================================
package rfsoc_config;

    localparam int unsigned DEFAULT_DATA_W = 256;
    localparam int unsigned DEFAULT_CNT_W  = 32;
    localparam int unsigned DEFAULT_SHOT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE      = 3'd1,
        ST_RUN      = 3'd2,
        ST_POST     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } pb_state_e;

    // First phase of a shot that actually has beats in it. A shot whose
    // phases are all empty collapses straight to WAIT_LOW.
    function automatic pb_state_e first_phase(input logic pre_nz,
                                              input logic run_nz,
                                              input logic post_nz);
        if (pre_nz)  return ST_PRE;
        if (run_nz)  return ST_RUN;
        if (post_nz) return ST_POST;
        return ST_WAIT_LOW;
    endfunction

endpackage : rfsoc_config
`default_nettype wire

// File: rtl/dac_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dac_beat_counter
//  Description : Loadable down-counter used to count accepted DAC beats of one
//                playback phase. Saturates at zero instead of wrapping.
//  Ports       : clk, rst (async, active-low)
//                load_i / load_val_i : load a new count (has priority)
//                en_i                : decrement by one (stops at zero)
//                cnt_o               : current count
//                zero_o              : count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_beat_counter
    import rfsoc_config::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule : dac_beat_counter
`default_nettype wire

// File: rtl/dac_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dac_playback_ctrl
//  Description : Triggered waveform playback into an RFSoC DAC stream. On a
//                trigger it plays cfg_shots framed shots, each made of
//                pre-delay zero beats, cycle_count waveform beats pulled from
//                the FIFO (optionally edge-masked) and post-delay zero beats.
//                Between runs the idle locking waveform is streamed.
//  Ports       : clk, rst (async, active-low)
//                s_axis_*        : waveform FIFO input (tready combinational)
//                m_axis_*        : DAC output stream (tvalid always 1)
//                trigger_in      : level start, must drop before re-arming
//                abort_in        : level abort of an active run
//                cfg_*           : run configuration, captured at start
//                loopback_valid  : consumed beat is being written back
//                busy / done     : not idle / one-cycle completion pulse
//                underrun        : sticky FIFO starvation seen in this run
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_playback_ctrl
    import rfsoc_config::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W,
    parameter int unsigned SHOT_W = DEFAULT_SHOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              trigger_in,
    input  logic              abort_in,
    input  logic [CNT_W-1:0]  cfg_cycle_count,
    input  logic [CNT_W-1:0]  cfg_pre_delay,
    input  logic [CNT_W-1:0]  cfg_post_delay,
    input  logic [SHOT_W-1:0] cfg_shots,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              cfg_mask_en,
    input  logic [DATA_W-1:0] cfg_lock_wave,
    output logic              loopback_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [SHOT_W-1:0] C_SHOT_ONE = SHOT_W'(1);

    pb_state_e         state_q, state_d;
    logic [SHOT_W-1:0] shots_q, shots_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;

    // Captured configuration; a run never sees later cfg_* changes.
    logic [CNT_W-1:0]  len_q, pre_q, post_q;
    logic [DATA_W-1:0] mask_q, lock_q;
    logic              mask_en_q;

    logic              snap;
    logic              cnt_load;
    logic              pre_en, run_en, post_en;
    logic [CNT_W-1:0]  pre_ld, run_ld, post_ld;
    logic [CNT_W-1:0]  pre_cnt, run_cnt, post_cnt;
    logic              pre_zero, run_zero, post_zero;

    logic              beat;
    logic              in_shot;
    logic              abort_hit;
    logic              run_first, run_last;
    logic              phase_end;
    pb_state_e         phase_next;
    logic [DATA_W-1:0] run_beat;

    assign beat      = m_axis_tready;
    assign in_shot   = (state_q == ST_PRE) || (state_q == ST_RUN) || (state_q == ST_POST);
    assign abort_hit = in_shot && abort_in;

    // A new run loads the counters from the live cfg_* ports; later shots of
    // the same run reload them from the captured copies.
    assign pre_ld  = (state_q == ST_IDLE) ? cfg_pre_delay   : pre_q;
    assign run_ld  = (state_q == ST_IDLE) ? cfg_cycle_count : len_q;
    assign post_ld = (state_q == ST_IDLE) ? cfg_post_delay  : post_q;

    dac_beat_counter #(.CNT_W(CNT_W)) u_pre_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (pre_ld),
        .en_i       (pre_en),
        .cnt_o      (pre_cnt),
        .zero_o     (pre_zero)
    );

    dac_beat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (run_ld),
        .en_i       (run_en),
        .cnt_o      (run_cnt),
        .zero_o     (run_zero)
    );

    dac_beat_counter #(.CNT_W(CNT_W)) u_post_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (post_ld),
        .en_i       (post_en),
        .cnt_o      (post_cnt),
        .zero_o     (post_zero)
    );

    // The run counter starts at the full length, so "first" is count==len and
    // "last" is count==1. With a one-beat shot both hold; first wins below.
    assign run_first = (run_cnt == len_q);
    assign run_last  = (run_cnt == C_CNT_ONE);

    always_comb begin
        state_d    = state_q;
        shots_d    = shots_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        snap       = 1'b0;
        cnt_load   = 1'b0;
        pre_en     = 1'b0;
        run_en     = 1'b0;
        post_en    = 1'b0;
        phase_end  = 1'b0;
        phase_next = ST_WAIT_LOW;

        case (state_q)
            ST_IDLE: begin
                if (trigger_in) begin
                    snap       = 1'b1;
                    cnt_load   = 1'b1;
                    underrun_d = 1'b0;
                    shots_d    = (cfg_shots == '0) ? C_SHOT_ONE : cfg_shots;
                    state_d    = first_phase(cfg_pre_delay != '0,
                                             cfg_cycle_count != '0,
                                             cfg_post_delay != '0);
                    // Every phase empty: the whole run completes at once.
                    done_d     = (state_d == ST_WAIT_LOW);
                end
            end
            ST_PRE: begin
                if (beat) begin
                    pre_en = 1'b1;
                    if (pre_zero || (pre_cnt == C_CNT_ONE)) begin
                        phase_end  = 1'b1;
                        phase_next = first_phase(1'b0, len_q != '0, post_q != '0);
                    end
                end
            end
            ST_RUN: begin
                if (beat) begin
                    run_en = 1'b1;
                    if (!s_axis_tvalid) begin
                        underrun_d = 1'b1;
                    end
                    if (run_zero || run_last) begin
                        phase_end  = 1'b1;
                        phase_next = first_phase(1'b0, 1'b0, post_q != '0);
                    end
                end
            end
            ST_POST: begin
                if (beat) begin
                    post_en = 1'b1;
                    if (post_zero || (post_cnt == C_CNT_ONE)) begin
                        phase_end = 1'b1;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (!trigger_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of a phase: either the next phase of this shot, the next shot,
        // or completion of the run.
        if (phase_end) begin
            if (phase_next != ST_WAIT_LOW) begin
                state_d = phase_next;
            end else if (shots_q > C_SHOT_ONE) begin
                shots_d  = shots_q - C_SHOT_ONE;
                cnt_load = 1'b1;
                state_d  = first_phase(pre_q != '0, len_q != '0, post_q != '0);
            end else begin
                state_d = ST_WAIT_LOW;
                done_d  = 1'b1;
            end
        end

        // Abort overrides everything, including a completion in this cycle.
        if (abort_hit) begin
            state_d    = ST_WAIT_LOW;
            shots_d    = shots_q;
            done_d     = 1'b0;
            underrun_d = underrun_q;
            cnt_load   = 1'b0;
            pre_en     = 1'b0;
            run_en     = 1'b0;
            post_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shots_q    <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            len_q      <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            mask_q     <= '0;
            mask_en_q  <= 1'b0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            shots_q    <= shots_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            if (snap) begin
                len_q     <= cfg_cycle_count;
                pre_q     <= cfg_pre_delay;
                post_q    <= cfg_post_delay;
                mask_q    <= cfg_mask;
                mask_en_q <= cfg_mask_en;
                lock_q    <= cfg_lock_wave;
            end
        end
    end

    always_comb begin
        run_beat = s_axis_tdata;
        if (!s_axis_tvalid) begin
            run_beat = '0;
        end else if (mask_en_q && run_first) begin
            run_beat = s_axis_tdata & mask_q;
        end else if (mask_en_q && run_last) begin
            run_beat = s_axis_tdata & ~mask_q;
        end
    end

    always_comb begin
        case (state_q)
            ST_IDLE:     m_axis_tdata = cfg_lock_wave;
            ST_RUN:      m_axis_tdata = run_beat;
            ST_WAIT_LOW: m_axis_tdata = lock_q;
            default:     m_axis_tdata = '0;
        endcase
    end

    assign s_axis_tready  = (state_q == ST_RUN) && m_axis_tready && !abort_in;
    assign loopback_valid = (state_q == ST_RUN) && s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid  = 1'b1;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign underrun       = underrun_q;

endmodule : dac_playback_ctrl
`default_nettype wire

// File: tb/tb_dac_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_playback_ctrl
//  Description : Self-checking bench for dac_playback_ctrl. A directed vector
//                table, hand-written corner sequences and randomized runs are
//                checked against a beat-schedule reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_playback_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 4;

    localparam int K_ZERO  = 0;
    localparam int K_FIRST = 1;
    localparam int K_MID   = 2;
    localparam int K_LAST  = 3;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          trigger_in;
    logic          abort_in;
    logic [CW-1:0] cfg_cycle_count;
    logic [CW-1:0] cfg_pre_delay;
    logic [CW-1:0] cfg_post_delay;
    logic [SW-1:0] cfg_shots;
    logic [DW-1:0] cfg_mask;
    logic          cfg_mask_en;
    logic [DW-1:0] cfg_lock_wave;
    logic          loopback_valid;
    logic          busy;
    logic          done;
    logic          underrun;

    dac_playback_ctrl #(.DATA_W(DW), .CNT_W(CW), .SHOT_W(SW)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .trigger_in      (trigger_in),
        .abort_in        (abort_in),
        .cfg_cycle_count (cfg_cycle_count),
        .cfg_pre_delay   (cfg_pre_delay),
        .cfg_post_delay  (cfg_post_delay),
        .cfg_shots       (cfg_shots),
        .cfg_mask        (cfg_mask),
        .cfg_mask_en     (cfg_mask_en),
        .cfg_lock_wave   (cfg_lock_wave),
        .loopback_valid  (loopback_valid),
        .busy            (busy),
        .done            (done),
        .underrun        (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: on a start the whole run is expanded into a queue of
    // beat kinds; each accepted beat pops one entry.
    // ------------------------------------------------------------------
    int          mq[$];
    int          m_mode;
    logic        m_und;
    logic        m_done;
    logic [DW-1:0] m_mask;
    logic        m_men;
    logic [DW-1:0] m_lock;

    int obs_rdy, obs_cons, obs_done;

    function automatic void model_reset();
        mq.delete();
        m_mode = M_IDLE;
        m_und  = 1'b0;
        m_done = 1'b0;
        m_mask = '0;
        m_men  = 1'b0;
        m_lock = '0;
    endfunction

    function automatic void build_queue();
        int shots;
        int cyc;
        shots = (cfg_shots == 0) ? 1 : int'(cfg_shots);
        cyc   = int'(cfg_cycle_count);
        mq.delete();
        for (int s = 0; s < shots; s++) begin
            for (int i = 0; i < int'(cfg_pre_delay); i++) mq.push_back(K_ZERO);
            for (int i = 0; i < cyc; i++)
                mq.push_back((i == 0) ? K_FIRST : ((i == cyc - 1) ? K_LAST : K_MID));
            for (int i = 0; i < int'(cfg_post_delay); i++) mq.push_back(K_ZERO);
        end
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int k, input logic [DW-1:0] d, input logic v);
        if (k == K_ZERO || !v) return '0;
        if (m_men && k == K_FIRST) return d & m_mask;
        if (m_men && k == K_LAST) return d & ~m_mask;
        return d;
    endfunction

    function automatic void model_update();
        logic nd;
        int   k;
        nd = 1'b0;
        if (rst) begin
            case (m_mode)
                M_IDLE: if (trigger_in) begin
                    m_mask = cfg_mask;
                    m_men  = cfg_mask_en;
                    m_lock = cfg_lock_wave;
                    m_und  = 1'b0;
                    build_queue();
                    if (mq.size() == 0) begin
                        m_mode = M_WAIT;
                        nd     = 1'b1;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (abort_in) begin
                        mq.delete();
                        m_mode = M_WAIT;
                    end else if (m_axis_tready) begin
                        k = mq.pop_front();
                        if (k != K_ZERO && !s_axis_tvalid) m_und = 1'b1;
                        if (mq.size() == 0) begin
                            m_mode = M_WAIT;
                            nd     = 1'b1;
                        end
                    end
                end
                default: if (!trigger_in) m_mode = M_IDLE;
            endcase
            m_done = nd;
        end
    endfunction

    function automatic void check_outputs();
        logic [DW-1:0] e_data;
        logic          e_rdy, e_lb, e_busy;
        int            k;
        e_data = cfg_lock_wave;
        e_rdy  = 1'b0;
        e_lb   = 1'b0;
        e_busy = 1'b0;
        if (m_mode == M_RUN) begin
            k      = mq[0];
            e_busy = 1'b1;
            e_data = exp_beat(k, s_axis_tdata, s_axis_tvalid);
            if (k != K_ZERO) begin
                e_rdy = m_axis_tready && !abort_in;
                e_lb  = e_rdy && s_axis_tvalid;
            end
        end else if (m_mode == M_WAIT) begin
            e_busy = 1'b1;
            e_data = m_lock;
        end
        chk("m_tdata", m_axis_tdata, e_data);
        chk("m_tvalid", m_axis_tvalid, 1);
        chk("s_tready", s_axis_tready, e_rdy);
        chk("loopback", loopback_valid, e_lb);
        chk("busy", busy, e_busy);
        chk("done", done, m_done);
        chk("underrun", underrun, m_und);
        obs_rdy  += int'(s_axis_tready);
        obs_cons += int'(s_axis_tready && s_axis_tvalid);
        obs_done += int'(done);
    endfunction

    // Inputs are set just after a rising edge; check mid-cycle, then advance.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_obs();
        obs_rdy  = 0;
        obs_cons = 0;
        obs_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic set_cfg(input int cyc, input int pre, input int post, input int shots,
                           input logic [DW-1:0] mask, input logic men, input logic [DW-1:0] lock);
        cfg_cycle_count = CW'(cyc);
        cfg_pre_delay   = CW'(pre);
        cfg_post_delay  = CW'(post);
        cfg_shots       = SW'(shots);
        cfg_mask        = mask;
        cfg_mask_en     = men;
        cfg_lock_wave   = lock;
    endtask

    task automatic run_until_wait(input string name, input int budget);
        for (int i = 0; i < budget && m_mode != M_WAIT; i++) step();
        chk({name, "_reached_wait"}, (m_mode == M_WAIT), 1);
    endtask

    typedef struct packed {
        logic          trig;
        logic          mrdy;
        logic          svld;
        logic [DW-1:0] sdata;
        logic [DW-1:0] exp_data;
        logic          exp_srdy;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Basic framed shot: pre=2, cycle=4, post=3, masked edges.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h0034, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h5678, 16'h5678, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h9ABC, 16'h9ABC, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'hDEF0, 16'hDE00, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h3333, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'h4444, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h6666, 16'hA5A5, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h7777, 16'hA5A5, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h8888, 16'hA5A5, 1'b0, 1'b0, 1'b0};

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        trigger_in    = 1'b0;
        abort_in      = 1'b0;
        set_cfg(4, 2, 3, 1, 16'h00FF, 1'b1, 16'hA5A5);
        clear_obs();
        model_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("reset_tdata", m_axis_tdata, 16'hA5A5);
        chk("reset_tvalid", m_axis_tvalid, 1);
        chk("reset_busy", busy, 0);
        chk("reset_srdy", s_axis_tready, 0);
        @(posedge clk);
        #1;
        do_reset();

        // ---------------- table-driven directed shot ----------------
        for (int i = 0; i < 13; i++) begin
            trigger_in    = vecs[i].trig;
            m_axis_tready = vecs[i].mrdy;
            s_axis_tvalid = vecs[i].svld;
            s_axis_tdata  = vecs[i].sdata;
            @(negedge clk);
            chk($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].exp_data);
            chk($sformatf("vec%0d_srdy", i), s_axis_tready, vecs[i].exp_srdy);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            @(posedge clk);
            #1;
        end

        // ---------------- three shots per trigger ----------------
        do_reset();
        set_cfg(2, 1, 1, 3, 16'hF00F, 1'b1, 16'h1357);
        clear_obs();
        trigger_in = 1'b1;
        s_axis_tdata = 16'hBEEF;
        run_until_wait("shots3", 60);
        step();
        chk("shots3_consumed", obs_cons, 6);
        chk("shots3_done_pulses", obs_done, 1);
        trigger_in = 1'b0;
        step();
        step();

        // ---------------- FIFO starvation on beats 3-4 ----------------
        do_reset();
        set_cfg(8, 0, 0, 1, 16'h0F0F, 1'b1, 16'h5A5A);
        clear_obs();
        trigger_in = 1'b1;
        step();
        for (int b = 1; b <= 8; b++) begin
            s_axis_tdata  = DW'($urandom);
            s_axis_tvalid = !(b == 3 || b == 4);
            step();
        end
        s_axis_tvalid = 1'b1;
        step();
        chk("starve_underrun", underrun, 1);
        chk("starve_beats", obs_rdy, 8);
        chk("starve_consumed", obs_cons, 6);
        chk("starve_done", obs_done, 1);
        trigger_in = 1'b0;
        step();
        step();

        // ---------------- abort at run beat 5 of 10 ----------------
        do_reset();
        set_cfg(10, 0, 0, 1, 16'h00FF, 1'b0, 16'h2468);
        clear_obs();
        trigger_in = 1'b1;
        step();
        for (int b = 1; b <= 4; b++) begin
            s_axis_tdata = DW'($urandom);
            step();
        end
        abort_in = 1'b1;
        #1;
        chk("abort_srdy_same_cycle", s_axis_tready, 0);
        step();
        abort_in = 1'b0;
        step();
        chk("abort_busy_waitlow", busy, 1);
        trigger_in = 1'b0;
        step();
        step();
        chk("abort_idle_after_low", busy, 0);
        chk("abort_no_done", obs_done, 0);
        chk("abort_beats", obs_rdy, 4);

        // ---------------- DAC backpressure mid-run ----------------
        do_reset();
        set_cfg(6, 1, 1, 1, 16'hFF00, 1'b1, 16'h0F0F);
        clear_obs();
        trigger_in = 1'b1;
        step();
        step();
        for (int b = 0; b < 2; b++) begin
            s_axis_tdata = DW'($urandom);
            step();
        end
        s_axis_tdata  = 16'hC3C3;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        m_axis_tready = 1'b1;
        run_until_wait("stall", 30);
        step();
        chk("stall_consumed", obs_cons, 6);
        chk("stall_beats", obs_rdy, 6);
        chk("stall_done", obs_done, 1);
        trigger_in = 1'b0;
        step();
        step();

        // ---------------- reset mid-run, trigger held ----------------
        do_reset();
        set_cfg(10, 0, 0, 1, 16'h0FF0, 1'b1, 16'h7E7E);
        trigger_in = 1'b1;
        step();
        for (int b = 1; b <= 4; b++) begin
            s_axis_tdata  = DW'($urandom);
            s_axis_tvalid = (b != 2);
            step();
        end
        s_axis_tvalid = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_run_srdy", s_axis_tready, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_done", done, 0);
        chk("rst_run_underrun", underrun, 0);
        chk("rst_run_lb", loopback_valid, 0);
        chk("rst_run_tdata", m_axis_tdata, 16'h7E7E);
        chk("rst_run_tvalid", m_axis_tvalid, 1);
        model_reset();
        step();
        step();
        rst = 1'b1;
        clear_obs();
        run_until_wait("restart", 40);
        step();
        chk("restart_consumed", obs_cons, 10);
        chk("restart_done", obs_done, 1);
        trigger_in = 1'b0;
        step();
        step();

        // ---------------- full-length counter ----------------
        do_reset();
        set_cfg(255, 0, 0, 1, 16'h0000, 1'b0, 16'h1111);
        clear_obs();
        trigger_in = 1'b1;
        run_until_wait("fulllen", 300);
        step();
        chk("fulllen_beats", obs_rdy, 255);
        trigger_in = 1'b0;
        step();
        step();

        // ---------------- randomized runs ----------------
        do_reset();
        for (int t = 0; t < 40; t++) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), DW'($urandom), 1'($urandom), DW'($urandom));
            trigger_in = 1'b1;
            for (int c = 0; c < 150 && m_mode != M_WAIT; c++) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                s_axis_tvalid = ($urandom_range(0, 7) != 0);
                s_axis_tdata  = DW'($urandom);
                abort_in      = ($urandom_range(0, 49) == 0);
                if (c > 0 && $urandom_range(0, 5) == 0)
                    set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), DW'($urandom), 1'($urandom), DW'($urandom));
                step();
            end
            chk("rand_reached_wait", (m_mode == M_WAIT), 1);
            abort_in = 1'b0;
            for (int c = 0; c < int'($urandom_range(0, 2)); c++) step();
            trigger_in    = 1'b0;
            cfg_lock_wave = DW'($urandom);
            step();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_dac_playback_ctrl
`default_nettype wire

// File: doc/dac_playback_ctrl.md
DAC_PLAYBACK_CTRL -- requirements
Module: dac_playback_ctrl

Interface
REQ-001 Parameter DATA_W, default 256: width of one DAC beat (16 samples x 16 bit at default).
REQ-002 Parameter CNT_W, default 32: width of beat and delay counters.
REQ-003 Parameter SHOT_W, default 16: width of shot-repeat count.
REQ-004 clk  in  1: DAC-side stream clock (250 MHz at default).
REQ-005 rst  in  1: reset, asynchronous, active-low.
REQ-006 s_axis_tdata  in  DATA_W: waveform beat from waveform FIFO.
REQ-007 s_axis_tvalid  in  1: FIFO beat valid.
REQ-008 s_axis_tready  out  1: beat consumed this cycle.
REQ-009 m_axis_tdata  out  DATA_W: beat to RFSoC DAC.
REQ-010 m_axis_tvalid  out  1: tied 1.
REQ-011 m_axis_tready  in  1: DAC accepting; all counters advance only when high.
REQ-012 trigger_in  in  1: level start; abort_in  in  1: level abort.
REQ-013 cfg_cycle_count  in  CNT_W: beats per shot; cfg_pre_delay, cfg_post_delay  in  CNT_W: zero-beats before/after each shot.
REQ-014 cfg_shots  in  SHOT_W: shots per trigger; 0 treated as 1.
REQ-015 cfg_mask  in  DATA_W; cfg_mask_en  in  1; cfg_lock_wave  in  DATA_W: idle locking waveform.
REQ-016 loopback_valid  out  1: beat being written back to FIFO; busy  out  1: state != IDLE; done  out  1: one-cycle completion pulse; underrun  out  1: sticky FIFO-starvation flag.

Function
REQ-017 States: IDLE, PRE, RUN, POST, WAIT_LOW; encoded as a package enum.
REQ-018 IDLE: trigger_in=1 snapshots all cfg_* into internal registers, clears underrun, loads shot counter; next state PRE, or RUN if pre_delay=0, or POST if cycle_count=0.
REQ-019 cfg_* changes outside IDLE-with-trigger have no effect on a run in progress.
REQ-020 PRE: outputs zero for exactly pre_delay accepted beats, then RUN (or POST if cycle_count=0).
REQ-021 RUN: s_axis_tready = m_axis_tready, combinational; exactly cycle_count beats consumed per shot; then POST.
REQ-022 RUN output: first beat of shot = s_tdata & cfg_mask; last beat = s_tdata & ~cfg_mask; other beats = s_tdata; masking only when cfg_mask_en=1; cycle_count=1 applies first-beat rule only.
REQ-023 RUN with s_axis_tvalid=0 while m_axis_tready=1: output zero, beat still counted, underrun set until next start.
REQ-024 loopback_valid = RUN & s_axis_tvalid & s_axis_tready.
REQ-025 POST: zero output for post_delay accepted beats; then, if shots remain, PRE of next shot without retrigger, else WAIT_LOW with done pulsed on entry.
REQ-026 WAIT_LOW: output cfg_lock_wave; return to IDLE only once trigger_in=0.
REQ-027 IDLE output: cfg_lock_wave (live, not snapshot); s_axis_tready=0 outside RUN.
REQ-028 abort_in=1 in PRE/RUN/POST: next state WAIT_LOW, s_axis_tready low same cycle, done not pulsed; ignored in IDLE/WAIT_LOW.
REQ-029 abort and completion in same cycle: abort wins (no done).
REQ-030 m_axis_tready=0: state, counters and output beat held; mask position not advanced.
REQ-031 Counters never wrap: decrement stops at 0; cfg_cycle_count=2^CNT_W-1 runs full length.

Reset
REQ-032 rst low: state IDLE, all counters 0, s_axis_tready 0, loopback_valid 0, done 0, underrun 0, busy 0, m_axis_tdata = cfg_lock_wave; m_axis_tvalid stays 1.
REQ-033 rst mid-RUN: immediate return to IDLE; no partial beat tracked; restart requires new trigger.

Structure
REQ-034 rfsoc_config package holds state enum typedef and default DATA_W/CNT_W/SHOT_W constants.
REQ-035 One sub-module, dac_beat_counter: loadable CNT_W down-counter with enable and zero flag, instanced for pre, run, post.

Verification
REQ-036 cycle_count=4, pre=2, post=3, shots=1, mask_en=1, mask=0x00FF: 2 zero beats, data&mask, 2 raw, data&~mask, 3 zero, done, lock wave.
REQ-037 shots=3, cycle_count=2, pre=1, post=1: 6 beats consumed, 3 framed shots, single done after third POST.
REQ-038 cycle_count=8, FIFO tvalid low for beats 3-4: zeros on those beats, underrun=1, still 8 beats counted.
REQ-039 abort_in at RUN beat 5 of 10: tready low same cycle, WAIT_LOW, no done; IDLE after trigger low.
REQ-040 m_axis_tready low 5 cycles mid-RUN: output and counters frozen; total consumed equals cycle_count.
REQ-041 rst asserted mid-RUN: outputs per REQ-032 immediately; trigger held high restarts cleanly after rst release.
